// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one core memory port between instruction fetch
// (imem) and the LSU (dmem). dmem is favoured, a saturating streak counter
// bounds how long fetch can wait, and an issued request keeps its owner
// until the downstream grant arrives.
module core_mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        imem_req,
  input  logic [63:0] imem_addr,
  output logic        imem_gnt,
  output logic        imem_err,
  output logic [63:0] imem_rdata,
  input  logic        dmem_req,
  input  logic [63:0] dmem_addr,
  input  logic        dmem_wen,
  input  logic [7:0]  dmem_strb,
  input  logic [63:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_err,
  output logic [63:0] dmem_rdata,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_strb,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_err,
  input  logic [63:0] mem_rdata,
  output logic        mem_owner
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic       OWNER_I    = 1'b0;
  localparam logic       OWNER_D    = 1'b1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       lock_owner_r;
  logic       lock_owner_nxt_s;
  logic [3:0] d_streak_r;
  logic [3:0] d_streak_nxt_s;
  logic       sel_s;
  logic       sel_req_s;
  logic       done_s;

  // Pick the requester that owns the downstream port this cycle.
  always_comb begin
    sel_s = lock_owner_r;
    if (state_r == ST_LOCKED) begin
      sel_s = lock_owner_r;
    end else if (imem_req && dmem_req) begin
      sel_s = (d_streak_r >= STREAK_MAX) ? OWNER_I : OWNER_D;
    end else if (dmem_req) begin
      sel_s = OWNER_D;
    end else if (imem_req) begin
      sel_s = OWNER_I;
    end else begin
      sel_s = lock_owner_r;
    end
  end

  // Selected request; reset masks everything visible downstream and upstream.
  assign sel_req_s = (sel_s == OWNER_D) ? dmem_req : imem_req;
  assign mem_req   = sel_req_s & ~g_reset;
  assign done_s    = mem_req & mem_gnt;

  // Downstream mux: fetches never write, so write fields are zeroed for imem.
  assign mem_addr  = (sel_s == OWNER_D) ? dmem_addr : imem_addr;
  assign mem_wen   = (sel_s == OWNER_D) ? dmem_wen : 1'b0;
  assign mem_strb  = (sel_s == OWNER_D) ? dmem_strb : 8'h00;
  assign mem_wdata = (sel_s == OWNER_D) ? dmem_wdata : 64'h0;
  assign mem_owner = sel_s & ~g_reset;

  // Responses: data/error broadcast, grant steered to the selected owner.
  assign imem_gnt   = done_s & (sel_s == OWNER_I);
  assign dmem_gnt   = done_s & (sel_s == OWNER_D);
  assign imem_err   = mem_err;
  assign dmem_err   = mem_err;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  // Lock transitions and streak bookkeeping for the next cycle.
  always_comb begin
    state_nxt_s      = state_r;
    lock_owner_nxt_s = lock_owner_r;
    d_streak_nxt_s   = d_streak_r;
    case (state_r)
      ST_UNLOCKED: begin
        if (mem_req && !mem_gnt) begin
          state_nxt_s      = ST_LOCKED;
          lock_owner_nxt_s = sel_s;
        end else begin
          state_nxt_s = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        // A dropped request from the locked owner releases the port too.
        if (mem_gnt || !sel_req_s) begin
          state_nxt_s = ST_UNLOCKED;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_UNLOCKED;
      end
    endcase
    if (done_s) begin
      if ((sel_s == OWNER_D) && imem_req) begin
        if (d_streak_r >= STREAK_MAX) begin
          d_streak_nxt_s = STREAK_MAX;
        end else begin
          d_streak_nxt_s = d_streak_r + 4'd1;
        end
      end else begin
        d_streak_nxt_s = 4'd0;
      end
    end else begin
      d_streak_nxt_s = d_streak_r;
    end
  end

  // State registers with synchronous reset; reset abandons any open lock.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_r      <= ST_UNLOCKED;
      lock_owner_r <= 1'b0;
      d_streak_r   <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      lock_owner_r <= lock_owner_nxt_s;
      d_streak_r   <= d_streak_nxt_s;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Testbench for core_mem_arbiter: directed scenarios plus random traffic,
// a transaction-level arbitration model and a response scoreboard.
module tb_core_mem_arbiter;

  localparam int MAX = 4;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_err;
  logic [63:0] imem_rdata;
  logic        dmem_req;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [7:0]  dmem_strb;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_err;
  logic [63:0] dmem_rdata;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;
  logic        mem_owner;

  core_mem_arbiter #(.MAX_D_STREAK(MAX)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_err(mem_err), .mem_rdata(mem_rdata), .mem_owner(mem_owner)
  );

  always #5 g_clk = ~g_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [64:0] i_q[$];
  logic [64:0] d_q[$];
  int          lat_cfg = 0;
  logic        i_got, d_got, req_seen, owner_seen, derr_seen, wen_seen;
  logic [7:0]  strb_seen;

  // Memory contents are a fixed function of the address.
  function automatic logic [63:0] rfun(input logic [63:0] a);
    return {a[31:0], a[63:32]} ^ 64'hC3C3_5A5A_0F0F_A5A5;
  endfunction

  function automatic logic efun(input logic [63:0] a);
    return ^a[7:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: latency lat_cfg (or random 0..3 when negative).
  initial begin : mem_model
    int lat;
    bit busy;
    lat = 0; busy = 1'b0;
    mem_gnt = 1'b0; mem_err = 1'b0; mem_rdata = 64'h0;
    forever begin
      @(posedge g_clk); #2;
      if (g_reset) begin
        busy = 1'b0; mem_gnt = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
          busy = 1'b1;
        end
        if (lat == 0) begin
          mem_gnt = 1'b1; busy = 1'b0;
        end else begin
          mem_gnt = 1'b0; lat--;
        end
      end else begin
        mem_gnt = 1'b0; busy = 1'b0;
      end
      mem_rdata = rfun(mem_addr);
      mem_err   = efun(mem_addr);
    end
  end

  // Arbitration reference: who must own the port, and whether it completes.
  initial begin : arb_model
    bit m_busy;
    int m_owner, m_streak, ex;
    bit done;
    m_busy = 1'b0; m_owner = 0; m_streak = 0;
    forever begin
      @(negedge g_clk);
      if (g_reset) begin
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_imem_gnt", 64'(imem_gnt), 64'd0);
        chk("rst_dmem_gnt", 64'(dmem_gnt), 64'd0);
        chk("rst_owner", 64'(mem_owner), 64'd0);
        m_busy = 1'b0; m_streak = 0;
      end else begin
        if (m_busy) ex = m_owner;
        else if (imem_req && dmem_req) ex = (m_streak >= MAX) ? 0 : 1;
        else if (dmem_req) ex = 1;
        else if (imem_req) ex = 0;
        else ex = -1;
        if (ex < 0) begin
          chk("idle_mem_req", 64'(mem_req), 64'd0);
          chk("idle_gnts", 64'({imem_gnt, dmem_gnt}), 64'd0);
        end else begin
          chk("mem_req", 64'(mem_req), 64'd1);
          chk("mem_owner", 64'(mem_owner), 64'(ex));
          chk("mem_addr", mem_addr, (ex == 1) ? dmem_addr : imem_addr);
          chk("mem_wen", 64'(mem_wen), (ex == 1) ? 64'(dmem_wen) : 64'd0);
          chk("mem_strb", 64'(mem_strb), (ex == 1) ? 64'(dmem_strb) : 64'd0);
          chk("mem_wdata", mem_wdata, (ex == 1) ? dmem_wdata : 64'd0);
          done = mem_gnt;
          chk("imem_gnt", 64'(imem_gnt), 64'(done && ex == 0));
          chk("dmem_gnt", 64'(dmem_gnt), 64'(done && ex == 1));
          if (done) begin
            m_busy = 1'b0;
            if (ex == 1 && imem_req) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
            else m_streak = 0;
          end else begin
            m_busy = 1'b1; m_owner = ex;
          end
        end
      end
    end
  end

  // Response scoreboard: every gnt must match the oldest outstanding request.
  initial begin : scoreboard
    logic [64:0] e;
    forever begin
      @(negedge g_clk);
      if (!g_reset && imem_gnt) begin
        if (i_q.size() == 0) chk("imem_unexpected_gnt", 64'd1, 64'd0);
        else begin
          e = i_q.pop_front();
          chk("imem_rdata", imem_rdata, e[63:0]);
          chk("imem_err", 64'(imem_err), 64'(e[64]));
        end
      end
      if (!g_reset && dmem_gnt) begin
        if (d_q.size() == 0) chk("dmem_unexpected_gnt", 64'd1, 64'd0);
        else begin
          e = d_q.pop_front();
          chk("dmem_rdata", dmem_rdata, e[63:0]);
          chk("dmem_err", 64'(dmem_err), 64'(e[64]));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge g_clk);
    i_got = imem_gnt; d_got = dmem_gnt; req_seen = mem_req; owner_seen = mem_owner;
    derr_seen = dmem_err; wen_seen = mem_wen; strb_seen = mem_strb;
    @(posedge g_clk); #1;
  endtask

  task automatic drop_granted();
    if (i_got) imem_req = 1'b0;
    if (d_got) dmem_req = 1'b0;
  endtask

  task automatic issue_i(input logic [63:0] a);
    imem_req = 1'b1; imem_addr = a;
    i_q.push_back({efun(a), rfun(a)});
  endtask

  task automatic issue_d(input logic [63:0] a, input logic w, input logic [7:0] s, input logic [63:0] wd);
    dmem_req = 1'b1; dmem_addr = a; dmem_wen = w; dmem_strb = s; dmem_wdata = wd;
    d_q.push_back({efun(a), rfun(a)});
  endtask

  task automatic run_until_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((imem_req || dmem_req) && n < bound) begin
      tick(); drop_granted(); n++;
    end
    chk(name, 64'(imem_req | dmem_req), 64'd0);
  endtask

  initial begin : main
    int req_cyc, gnt_cnt, dg, gcount, n, ig;
    g_reset = 1'b1;
    imem_req = 1'b0; imem_addr = 64'h0;
    dmem_req = 1'b0; dmem_addr = 64'h0; dmem_wen = 1'b0; dmem_strb = 8'h00; dmem_wdata = 64'h0;
    @(posedge g_clk); #1;
    // Requests during reset must be ignored.
    imem_req = 1'b1; imem_addr = 64'h10; dmem_req = 1'b1; dmem_addr = 64'h20;
    tick(); tick();
    imem_req = 1'b0; dmem_req = 1'b0; g_reset = 1'b0;
    tick();

    // Lone fetch, three-cycle memory.
    lat_cfg = 2; req_cyc = 0; gnt_cnt = 0; dg = 0;
    issue_i(64'h1000);
    for (int k = 0; k < 6; k++) begin
      tick();
      req_cyc += int'(req_seen); gnt_cnt += int'(i_got); dg += int'(d_got);
      drop_granted();
    end
    chk("fetch_req_cycles", 64'(req_cyc), 64'd3);
    chk("fetch_gnt_count", 64'(gnt_cnt), 64'd1);
    chk("fetch_no_dgnt", 64'(dg), 64'd0);

    // Continuous contention with zero-wait memory.
    lat_cfg = 0; gcount = 0; n = 0;
    issue_i({$urandom, $urandom}); issue_d({$urandom, $urandom}, 1'b0, 8'h00, 64'h0);
    while (gcount < 10 && n < 40) begin
      tick(); n++;
      if (i_got || d_got) begin
        chk("contention_order", 64'({i_got, d_got}), (gcount % (MAX + 1) == MAX) ? 64'd2 : 64'd1);
        gcount++;
      end
      if (gcount < 10) begin
        if (i_got) begin imem_req = 1'b0; issue_i({$urandom, $urandom}); end
        if (d_got) begin dmem_req = 1'b0; issue_d({$urandom, $urandom}, 1'b0, 8'h00, 64'h0); end
      end else drop_granted();
    end
    chk("contention_count", 64'(gcount), 64'd10);
    run_until_idle("contention_drain", 20);

    // Lock hold: imem issued at cycle 0, granted at 5; dmem raised at 1.
    lat_cfg = 5; ig = -1; dg = -1;
    issue_i(64'h3000);
    tick();
    chk("lock_owner_c0", 64'(owner_seen), 64'd0);
    drop_granted();
    issue_d(64'h4000, 1'b0, 8'h00, 64'h0);
    for (int c = 1; c < 12; c++) begin
      tick();
      if (c <= 5) chk("lock_owner", 64'(owner_seen), 64'd0);
      if (i_got) begin ig = c; lat_cfg = 0; end
      if (d_got) dg = c;
      drop_granted();
    end
    chk("lock_imem_gnt_cycle", 64'(ig), 64'd5);
    chk("lock_dmem_gnt_cycle", 64'(dg), 64'd6);

    // Streak reset: three dmem wins with imem waiting, one with imem absent.
    lat_cfg = 0;
    imem_req = 1'b1; imem_addr = 64'h5000;
    issue_d(64'h5100, 1'b0, 8'h00, 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("streak_dmem_win", 64'(d_got), 64'd1);
      drop_granted();
      issue_d(64'h5200 + 64'(k), 1'b0, 8'h00, 64'h0);
    end
    imem_req = 1'b0;
    tick();
    chk("streak_lone_dmem", 64'(d_got), 64'd1);
    drop_granted();
    issue_i(64'h5300); issue_d(64'h5400, 1'b0, 8'h00, 64'h0);
    tick();
    chk("streak_reset_next", 64'({i_got, d_got}), 64'd1);
    drop_granted();
    run_until_idle("streak_drain", 20);

    // Write with error response.
    lat_cfg = 1; n = 0;
    issue_d(64'h2001, 1'b1, 8'h0F, 64'h1234);
    d_got = 1'b0;
    while (!d_got && n < 6) begin tick(); n++; end
    chk("wr_gnt_seen", 64'(d_got), 64'd1);
    chk("wr_wen", 64'(wen_seen), 64'd1);
    chk("wr_strb", 64'(strb_seen), 64'h0F);
    chk("wr_err", 64'(derr_seen), 64'd1);
    drop_granted();

    // Reset while locked on dmem.
    lat_cfg = 5;
    issue_d(64'h6000, 1'b0, 8'h00, 64'h0);
    tick(); tick();
    g_reset = 1'b1;
    tick();
    chk("rst_mid_req", 64'(req_seen), 64'd0);
    chk("rst_mid_gnt", 64'({i_got, d_got}), 64'd0);
    tick();
    dmem_req = 1'b0; d_q.delete(); g_reset = 1'b0; lat_cfg = 0;
    issue_i(64'h7000);
    tick();
    chk("post_rst_req", 64'(req_seen), 64'd1);
    chk("post_rst_owner", 64'(owner_seen), 64'd0);
    chk("post_rst_gnt", 64'(i_got), 64'd1);
    drop_granted();

    // Random traffic with random memory latency.
    lat_cfg = -1;
    for (int k = 0; k < 2000; k++) begin
      tick();
      drop_granted();
      if (!imem_req && $urandom_range(0, 3) != 0) issue_i({$urandom, $urandom});
      if (!dmem_req && $urandom_range(0, 2) != 0)
        issue_d({$urandom, $urandom}, 1'($urandom), 8'($urandom), {$urandom, $urandom});
    end
    run_until_idle("random_drain", 50);
    tick();
    chk("imem_queue_empty", 64'(i_q.size()), 64'd0);
    chk("dmem_queue_empty", 64'(d_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
